// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer for Y = X^E mod C.
// Owns the BITxBIT multiplier and is the sole master of an external shared modulo unit.
module modexp_ctrl #(
  parameter int BIT  = 8,
  parameter int EBIT = 8,
  parameter int WDOG = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req,
  input  logic [BIT-1:0]  x,
  input  logic [EBIT-1:0] e,
  input  logic [BIT-1:0]  c,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [BIT-1:0]  y,
  output logic            mod_start,
  output logic [BIT-1:0]  mod_c,
  output logic [BIT:0]    mod_h,
  output logic [BIT-1:0]  mod_l,
  input  logic            mod_busy,
  input  logic [BIT-1:0]  mod_m
);

  localparam int IW = $clog2(EBIT + 1);
  localparam int WW = $clog2(WDOG + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RED, S_SQR, S_MUL, S_ISSUE, S_WAIT, S_REL, S_NXT, S_FIN
  } state_t;

  typedef enum logic [1:0] {OP_RED, OP_SQR, OP_MUL} op_t;

  state_t          state, state_n;
  op_t             op;
  logic [BIT-1:0]  x_reg, c_reg, r, xr, y_q;
  logic [EBIT-1:0] e_sh;
  logic [IW-1:0]   i_cnt;
  logic [WW-1:0]   wd;
  logic [2*BIT-1:0] p;
  logic            err_q;
  logic            wd_expire;

  assign wd_expire = (state == S_ISSUE) && !mod_busy && (wd == WW'(WDOG - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // RED/SQR/MUL are the product-register phases; every op then runs ISSUE -> WAIT -> REL.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (req) state_n = (c == '0) ? S_FIN : S_RED;
      S_RED, S_SQR, S_MUL: state_n = S_ISSUE;
      S_ISSUE: begin
        if (mod_busy)       state_n = S_WAIT;
        else if (wd_expire) state_n = S_FIN;
      end
      S_WAIT:  if (!mod_busy) state_n = S_REL;
      S_REL: begin
        case (op)
          OP_RED:  state_n = S_SQR;
          OP_SQR:  state_n = e_sh[EBIT-1] ? S_MUL : S_NXT;
          default: state_n = S_NXT;
        endcase
      end
      S_NXT:   state_n = (i_cnt == IW'(1)) ? S_FIN : S_SQR;
      S_FIN:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op    <= OP_RED;
      x_reg <= '0;
      c_reg <= '0;
      e_sh  <= '0;
      r     <= '0;
      xr    <= '0;
      y_q   <= '0;
      err_q <= 1'b0;
      i_cnt <= '0;
      wd    <= '0;
      p     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            x_reg <= x;
            e_sh  <= e;
            c_reg <= c;
            y_q   <= '0;
            err_q <= (c == '0);
            r     <= BIT'(1);
            i_cnt <= IW'(EBIT);
          end
        end
        S_RED: begin
          p  <= {{BIT{1'b0}}, x_reg};
          op <= OP_RED;
          wd <= '0;
        end
        S_SQR: begin
          p  <= {{BIT{1'b0}}, r} * {{BIT{1'b0}}, r};
          op <= OP_SQR;
          wd <= '0;
        end
        S_MUL: begin
          p  <= {{BIT{1'b0}}, r} * {{BIT{1'b0}}, xr};
          op <= OP_MUL;
          wd <= '0;
        end
        S_ISSUE: begin
          if (wd_expire) begin
            y_q   <= '0;
            err_q <= 1'b1;
          end else if (!mod_busy) begin
            wd <= wd + WW'(1);
          end
        end
        S_REL: begin
          if (op == OP_RED) xr <= mod_m;
          else              r  <= mod_m;
        end
        S_NXT: begin
          e_sh  <= e_sh << 1;
          i_cnt <= i_cnt - IW'(1);
          if (i_cnt == IW'(1)) y_q <= r;
        end
        default: ;
      endcase
    end
  end

  // The high product word never exceeds BIT bits since both factors are < c.
  assign mod_h     = {1'b0, p[2*BIT-1:BIT]};
  assign mod_l     = p[BIT-1:0];
  assign mod_c     = c_reg;
  assign mod_start = (state == S_ISSUE) || (state == S_WAIT);
  assign busy      = (state != S_IDLE) && (state != S_FIN);
  assign done      = (state == S_FIN);
  assign y         = y_q;
  assign err       = err_q;

endmodule

// File: tb/tb_modexp_ctrl.sv
// Directed bench for modexp_ctrl with a behavioural modulo-unit responder.
module tb_modexp_ctrl;

  localparam int BIT  = 8;
  localparam int EBIT = 8;
  localparam int WDOG = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req = 1'b0;
  logic [BIT-1:0]  x = '0;
  logic [EBIT-1:0] e = '0;
  logic [BIT-1:0]  c = '0;
  logic            busy, done, err, mod_start;
  logic [BIT-1:0]  y, mod_c, mod_l;
  logic [BIT:0]    mod_h;
  logic            mod_busy = 1'b0;
  logic [BIT-1:0]  mod_m = '0;

  int vec_count  = 0;
  int miscompares = 0;
  int starts = 0;
  int h8_bad = 0;
  logic start_prev = 1'b0;

  logic mu_en = 1'b1;
  logic mu_done = 1'b0;
  int   mu_cnt = 0;
  int   mu_lat = 3;

  modexp_ctrl #(.BIT(BIT), .EBIT(EBIT), .WDOG(WDOG)) dut (
    .clk(clk), .rst(rst), .req(req), .x(x), .e(e), .c(c),
    .busy(busy), .done(done), .err(err), .y(y),
    .mod_start(mod_start), .mod_c(mod_c), .mod_h(mod_h), .mod_l(mod_l),
    .mod_busy(mod_busy), .mod_m(mod_m)
  );

  always #5 clk = ~clk;

  // Modulo unit: held cleared while mod_start is low, one op per mod_start high period.
  always @(posedge clk) begin
    if (!mod_start) begin
      mod_busy <= 1'b0;
      mu_done  <= 1'b0;
      mu_cnt   <= 0;
    end else if (!mu_done && mu_en) begin
      if (!mod_busy) begin
        mod_busy <= 1'b1;
        mu_cnt   <= mu_lat;
      end else if (mu_cnt == 0) begin
        mod_busy <= 1'b0;
        mu_done  <= 1'b1;
        mod_m    <= (mod_c == '0) ? '0 : BIT'({mod_h, mod_l} % {9'd0, mod_c});
      end else begin
        mu_cnt <= mu_cnt - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (mod_start && !start_prev) begin
      starts = starts + 1;
      if (mod_h[BIT]) h8_bad = h8_bad + 1;
    end
    start_prev = mod_start;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] xv, input logic [7:0] ev, input logic [7:0] cv);
    x   = xv;
    e   = ev;
    c   = cv;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic runVector(input string tag, input logic [7:0] xv, input logic [7:0] ev,
                           input logic [7:0] cv, input logic [7:0] exp_y, input logic exp_err,
                           input int exp_ops, input bit pulse_mid, output int lat);
    bit seen;
    int cyc;
    starts = 0;
    h8_bad = 0;
    applyStimulus(xv, ev, cv);
    cyc  = 0;
    seen = 1'b0;
    while (cyc < 5000 && !seen) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (pulse_mid && cyc == 10) begin
          x = 8'd200; e = 8'd2; c = 8'd7; req = 1'b1;
        end else begin
          req = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    req = 1'b0;
    lat = cyc;
    checkOutput({tag, "_done"}, 32'(seen), 32'd1);
    checkOutput({tag, "_y"}, 32'(y), 32'(exp_y));
    checkOutput({tag, "_err"}, 32'(err), 32'(exp_err));
    checkOutput({tag, "_ops"}, starts, exp_ops);
    checkOutput({tag, "_h8"}, h8_bad, 0);
    @(negedge clk);
    checkOutput({tag, "_pulse"}, 32'({done, busy}), 32'd0);
  endtask

  initial begin
    int lat;
    int n;
    repeat (3) @(negedge clk);
    checkOutput("rst_ctl", 32'({busy, done, err, mod_start, y}), 32'd0);
    checkOutput("rst_dp", 32'({mod_h, mod_l, mod_c}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    runVector("v5_3_13", 8'd5, 8'd3, 8'd13, 8'd8, 1'b0, 11, 1'b0, lat);
    runVector("czero", 8'd5, 8'd3, 8'd0, 8'd0, 1'b1, 0, 1'b0, lat);
    checkOutput("czero_lat", 32'(lat <= 3), 32'd1);
    runVector("v200_2_7", 8'd200, 8'd2, 8'd7, 8'd2, 1'b0, 10, 1'b0, lat);
    runVector("v9_0_13", 8'd9, 8'd0, 8'd13, 8'd1, 1'b0, 9, 1'b0, lat);
    runVector("v9_5_1", 8'd9, 8'd5, 8'd1, 8'd0, 1'b0, 11, 1'b0, lat);
    runVector("v255", 8'd255, 8'd255, 8'd251, 8'd20, 1'b0, 17, 1'b0, lat);

    mu_en = 1'b0;
    runVector("wdog", 8'd5, 8'd3, 8'd13, 8'd0, 1'b1, 1, 1'b0, lat);
    mu_en = 1'b1;
    @(negedge clk);

    runVector("busy_req", 8'd5, 8'd3, 8'd13, 8'd8, 1'b0, 11, 1'b1, lat);

    // Reset while the controller sits in WAIT on the third op.
    starts = 0;
    applyStimulus(8'd255, 8'd255, 8'd251);
    n = 0;
    while (n < 2000 && !(starts >= 3 && mod_busy)) begin
      @(negedge clk);
      n++;
    end
    checkOutput("midrst_reach", 32'(n < 2000), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_ctl", 32'({busy, done, err, mod_start, y}), 32'd0);
    checkOutput("midrst_dp", 32'({mod_h, mod_l, mod_c}), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    runVector("after_rst", 8'd5, 8'd3, 8'd13, 8'd8, 1'b0, 11, 1'b0, lat);

    x = 8'd5; e = 8'd3; c = 8'd13;
    rst = 1'b1;
    req = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req = 1'b0;
    @(negedge clk);
    checkOutput("rst_req", 32'({busy, done, mod_start}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
